// File: rtl/vliw_id_regfile_if.sv
// ----------------------------------------------------------------------------
// vliw_id_regfile_if
//
// Purpose : Bundle of signals between the decode controller and the
//           register-read / forwarding unit of the multi-lane VLIW core.
//
// Signals (lane L, read port P):
//   stall, flush            controller -> unit   ID/EX hold / squash
//   rs_tag   [(2L+P)*ADDR_W +: ADDR_W]           source register tags
//   rd_tag   [L*ADDR_W +: ADDR_W]                destination tag per lane
//   cond     [2L +: 2]                           predicate field per lane
//   wb_*/ex_*/mem_*  (en, tag, data) per lane    result buses for forwarding
//   rs_val, rs_tag_q, rd_tag_q, lane_cnd         unit -> EX stage, registered
//
// Modports: master = controller side, slave = register-read unit.
// ----------------------------------------------------------------------------
interface vliw_id_regfile_if #(
    parameter int NLANES = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic                         stall;
    logic                         flush;
    logic [NLANES*2*ADDR_W-1:0]   rs_tag;
    logic [NLANES*ADDR_W-1:0]     rd_tag;
    logic [NLANES*2-1:0]          cond;

    logic [NLANES-1:0]            wb_en;
    logic [NLANES*ADDR_W-1:0]     wb_tag;
    logic [NLANES*DATA_W-1:0]     wb_data;
    logic [NLANES-1:0]            ex_en;
    logic [NLANES*ADDR_W-1:0]     ex_tag;
    logic [NLANES*DATA_W-1:0]     ex_data;
    logic [NLANES-1:0]            mem_en;
    logic [NLANES*ADDR_W-1:0]     mem_tag;
    logic [NLANES*DATA_W-1:0]     mem_data;

    logic [NLANES*2*DATA_W-1:0]   rs_val;
    logic [NLANES*2*ADDR_W-1:0]   rs_tag_q;
    logic [NLANES*ADDR_W-1:0]     rd_tag_q;
    logic [NLANES-1:0]            lane_cnd;

    modport master (
        output stall, flush, rs_tag, rd_tag, cond,
               wb_en, wb_tag, wb_data,
               ex_en, ex_tag, ex_data,
               mem_en, mem_tag, mem_data,
        input  rs_val, rs_tag_q, rd_tag_q, lane_cnd
    );

    modport slave (
        input  stall, flush, rs_tag, rd_tag, cond,
               wb_en, wb_tag, wb_data,
               ex_en, ex_tag, ex_data,
               mem_en, mem_tag, mem_data,
        output rs_val, rs_tag_q, rd_tag_q, lane_cnd
    );
endinterface

// File: rtl/vliw_id_regfile.sv
// ----------------------------------------------------------------------------
// vliw_id_regfile
//
// Purpose : Register file plus operand forwarding for the ID stage of the
//           multi-lane VLIW core. Each lane has two read ports; every read is
//           resolved against EX, MEM and WB results (in that priority, highest
//           lane winning within a stage) and against the register file, then
//           registered into the ID/EX boundary together with the tags and the
//           per-lane predicate result.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset
//   bus          vliw_id_regfile_if.slave (stall/flush, tags, cond, result
//                buses in; rs_val, rs_tag_q, rd_tag_q, lane_cnd out)
//   wr_conflict  sticky flag, present only when VLIW_ID_WR_CONFLICT_EN is
//                defined; set when two lanes write the same nonzero tag in
//                one cycle, cleared only by reset
//
// Optional feature macro: VLIW_ID_WR_CONFLICT_EN
// ----------------------------------------------------------------------------
module vliw_id_regfile #(
    parameter int NLANES   = 4,
    parameter int DATA_W   = 16,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int PRED_REG = 30
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef VLIW_ID_WR_CONFLICT_EN
    output logic              wr_conflict,
`endif
    vliw_id_regfile_if.slave  bus
);

    localparam int                NPORTS   = NLANES * 2;
    localparam logic [ADDR_W-1:0] PRED_TAG = ADDR_W'(PRED_REG);

    logic [NREGS-1:0][DATA_W-1:0]  r_rf;
    logic [NPORTS*DATA_W-1:0]      r_rs_val;
    logic [NPORTS*ADDR_W-1:0]      r_rs_tag_q;
    logic [NLANES*ADDR_W-1:0]      r_rd_tag_q;
    logic [NLANES-1:0]             r_lane_cnd;

    logic [NPORTS*DATA_W-1:0]      w_rs_res;
    logic [DATA_W-1:0]             w_pred;
    logic [NLANES-1:0]             w_cnd;

    // Resolve one tag against the result buses. Lanes are scanned upward so
    // the highest matching lane in each stage overwrites lower ones. Tag 0 is
    // the hardwired zero register and never forwards.
    function automatic logic [DATA_W-1:0] f_resolve(
        input logic [ADDR_W-1:0]        tag,
        input logic [DATA_W-1:0]        rf_val,
        input logic [NLANES-1:0]        ex_en,
        input logic [NLANES*ADDR_W-1:0] ex_tag,
        input logic [NLANES*DATA_W-1:0] ex_data,
        input logic [NLANES-1:0]        mem_en,
        input logic [NLANES*ADDR_W-1:0] mem_tag,
        input logic [NLANES*DATA_W-1:0] mem_data,
        input logic [NLANES-1:0]        wb_en,
        input logic [NLANES*ADDR_W-1:0] wb_tag,
        input logic [NLANES*DATA_W-1:0] wb_data
    );
        logic              hit_ex;
        logic              hit_mem;
        logic              hit_wb;
        logic [DATA_W-1:0] v_ex;
        logic [DATA_W-1:0] v_mem;
        logic [DATA_W-1:0] v_wb;
        logic [DATA_W-1:0] res;
        hit_ex  = 1'b0;
        hit_mem = 1'b0;
        hit_wb  = 1'b0;
        v_ex    = '0;
        v_mem   = '0;
        v_wb    = '0;
        for (int l = 0; l < NLANES; l++) begin
            if (ex_en[l] && (ex_tag[l*ADDR_W +: ADDR_W] == tag)) begin
                hit_ex = 1'b1;
                v_ex   = ex_data[l*DATA_W +: DATA_W];
            end
            if (mem_en[l] && (mem_tag[l*ADDR_W +: ADDR_W] == tag)) begin
                hit_mem = 1'b1;
                v_mem   = mem_data[l*DATA_W +: DATA_W];
            end
            if (wb_en[l] && (wb_tag[l*ADDR_W +: ADDR_W] == tag)) begin
                hit_wb = 1'b1;
                v_wb   = wb_data[l*DATA_W +: DATA_W];
            end
        end
        if (tag == '0)
            res = '0;
        else if (hit_ex)
            res = v_ex;
        else if (hit_mem)
            res = v_mem;
        else if (hit_wb)
            res = v_wb;
        else
            res = rf_val;
        return res;
    endfunction

    // Register file write. Lanes are applied in ascending order, so when
    // several lanes target the same register the highest lane's value lands.
    // Writes are independent of stall/flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rf <= '0;
        end else begin
            for (int l = 0; l < NLANES; l++) begin
                if (bus.wb_en[l] && (bus.wb_tag[l*ADDR_W +: ADDR_W] != '0))
                    r_rf[bus.wb_tag[l*ADDR_W +: ADDR_W]] <= bus.wb_data[l*DATA_W +: DATA_W];
            end
        end
    end

    // Operand resolution for every read port in the cycle the tag arrives.
    always_comb begin
        w_rs_res = '0;
        for (int p = 0; p < NPORTS; p++) begin
            w_rs_res[p*DATA_W +: DATA_W] = f_resolve(
                bus.rs_tag[p*ADDR_W +: ADDR_W],
                r_rf[bus.rs_tag[p*ADDR_W +: ADDR_W]],
                bus.ex_en,  bus.ex_tag,  bus.ex_data,
                bus.mem_en, bus.mem_tag, bus.mem_data,
                bus.wb_en,  bus.wb_tag,  bus.wb_data);
        end
    end

    // Predicate evaluation: the predicate register sees the same forwarding
    // as ordinary operands, so an in-flight compare result is honoured.
    always_comb begin
        w_pred = f_resolve(
            PRED_TAG,
            r_rf[PRED_TAG],
            bus.ex_en,  bus.ex_tag,  bus.ex_data,
            bus.mem_en, bus.mem_tag, bus.mem_data,
            bus.wb_en,  bus.wb_tag,  bus.wb_data);
        w_cnd = '0;
        for (int l = 0; l < NLANES; l++) begin
            case (bus.cond[2*l +: 2])
                2'b00:   w_cnd[l] = 1'b1;
                2'b01:   w_cnd[l] = (w_pred == '0);
                2'b10:   w_cnd[l] = (w_pred != '0);
                default: w_cnd[l] = 1'b0;
            endcase
        end
    end

    // ID/EX boundary: reset, then flush (all-zero tags turn lanes into NOPs),
    // then stall (hold; writebacks during the stall deliberately do not
    // refresh held operands since the controller re-presents the bundle).
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            r_rs_val   <= '0;
            r_rs_tag_q <= '0;
            r_rd_tag_q <= '0;
            r_lane_cnd <= '0;
        end else if (!bus.stall) begin
            r_rs_val   <= w_rs_res;
            r_rs_tag_q <= bus.rs_tag;
            r_rd_tag_q <= bus.rd_tag;
            r_lane_cnd <= w_cnd;
        end
    end

    assign bus.rs_val   = r_rs_val;
    assign bus.rs_tag_q = r_rs_tag_q;
    assign bus.rd_tag_q = r_rd_tag_q;
    assign bus.lane_cnd = r_lane_cnd;

`ifdef VLIW_ID_WR_CONFLICT_EN
    logic w_conflict;
    logic r_wr_conflict;

    // Any pair of lanes writing the same nonzero register this cycle.
    always_comb begin
        w_conflict = 1'b0;
        for (int l = 0; l < NLANES; l++) begin
            for (int m = l + 1; m < NLANES; m++) begin
                if (bus.wb_en[l] && bus.wb_en[m] &&
                    (bus.wb_tag[l*ADDR_W +: ADDR_W] == bus.wb_tag[m*ADDR_W +: ADDR_W]) &&
                    (bus.wb_tag[l*ADDR_W +: ADDR_W] != '0))
                    w_conflict = 1'b1;
            end
        end
    end

    // Sticky until reset so software can poll it at leisure.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_wr_conflict <= 1'b0;
        else if (w_conflict)
            r_wr_conflict <= 1'b1;
    end

    assign wr_conflict = r_wr_conflict;
`endif

endmodule

// File: tb/tb_vliw_id_regfile.sv
// ----------------------------------------------------------------------------
// tb_vliw_id_regfile
//
// Purpose : Self-checking bench for vliw_id_regfile. Stimulus is driven on the
//           falling edge; each expected response is queued with the cycle it
//           is due and a monitor samples just after the rising edge, popping
//           and comparing due entries.
// ----------------------------------------------------------------------------
module tb_vliw_id_regfile;

    localparam int NL = 4;
    localparam int DW = 16;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int VW = NL * 2 * DW;

    typedef enum {S_VAL, S_ALLVAL, S_ALLTAG, S_RDTAG, S_CND, S_CONF} sel_e;

    typedef struct {
        string          name;
        int             due;
        sel_e           sel;
        int             idx;
        logic [VW-1:0]  exp;
    } exp_t;

    exp_t  expQ[$];
    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;

    logic [NL*2*AW-1:0] allFive;
    logic [NL*AW-1:0]   rdX;

    vliw_id_regfile_if #(.NLANES(NL), .DATA_W(DW), .ADDR_W(AW)) bus ();

`ifdef VLIW_ID_WR_CONFLICT_EN
    logic wrConflict;
`endif

    vliw_id_regfile #(
        .NLANES   (NL),
        .DATA_W   (DW),
        .NREGS    (NR),
        .ADDR_W   (AW),
        .PRED_REG (30)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef VLIW_ID_WR_CONFLICT_EN
        .wr_conflict (wrConflict),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bound on total run time in case the flow ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: bench did not complete");
        $fatal(1, "[TB] timeout");
    end

    // Compare one queued expectation against the DUT outputs.
    task automatic checkOutput(input exp_t e);
        logic [VW-1:0] act;
        act = '0;
        case (e.sel)
            S_VAL:    act[DW-1:0]      = bus.rs_val[e.idx*DW +: DW];
            S_ALLVAL: act              = bus.rs_val;
            S_ALLTAG: act[NL*2*AW-1:0] = bus.rs_tag_q;
            S_RDTAG:  act[NL*AW-1:0]   = bus.rd_tag_q;
            S_CND:    act[NL-1:0]      = bus.lane_cnd;
`ifdef VLIW_ID_WR_CONFLICT_EN
            S_CONF:   act[0]           = wrConflict;
`endif
            default:  act              = '0;
        endcase
        checks++;
        if (act !== e.exp) begin
            failures++;
            $display("[TB] FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", e.name, cyc, act, e.exp);
        end
    endtask

    // Monitor: pops every expectation due at the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (expQ.size() > 0 && expQ[0].due <= cyc) begin
                e = expQ.pop_front();
                if (e.due < cyc) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL %s: due cycle %0d not sampled, now %0d", e.name, e.due, cyc);
                end else begin
                    checkOutput(e);
                end
            end
        end
    end

    task automatic clearInputs();
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.rs_tag   = '0;
        bus.rd_tag   = '0;
        bus.cond     = '0;
        bus.wb_en    = '0;
        bus.wb_tag   = '0;
        bus.wb_data  = '0;
        bus.ex_en    = '0;
        bus.ex_tag   = '0;
        bus.ex_data  = '0;
        bus.mem_en   = '0;
        bus.mem_tag  = '0;
        bus.mem_data = '0;
    endtask

    // Start a new stimulus cycle on the falling edge with idle inputs.
    task automatic applyStimulus();
        @(negedge clk);
        clearInputs();
    endtask

    // Queue an expectation for the outputs after the next rising edge.
    task automatic expectOut(input string name, input sel_e sel, input int idx, input logic [VW-1:0] v);
        exp_t e;
        e.name = name;
        e.due  = cyc + 1;
        e.sel  = sel;
        e.idx  = idx;
        e.exp  = v;
        expQ.push_back(e);
    endtask

    task automatic setRs(input int l, input int p, input logic [AW-1:0] t);
        bus.rs_tag[(2*l+p)*AW +: AW] = t;
    endtask

    task automatic setRd(input int l, input logic [AW-1:0] t);
        bus.rd_tag[l*AW +: AW] = t;
    endtask

    task automatic setCond(input int l, input logic [1:0] c);
        bus.cond[2*l +: 2] = c;
    endtask

    task automatic setWb(input int l, input logic [AW-1:0] t, input logic [DW-1:0] d);
        bus.wb_en[l]            = 1'b1;
        bus.wb_tag[l*AW +: AW]  = t;
        bus.wb_data[l*DW +: DW] = d;
    endtask

    task automatic setEx(input int l, input logic [AW-1:0] t, input logic [DW-1:0] d);
        bus.ex_en[l]            = 1'b1;
        bus.ex_tag[l*AW +: AW]  = t;
        bus.ex_data[l*DW +: DW] = d;
    endtask

    task automatic setMem(input int l, input logic [AW-1:0] t, input logic [DW-1:0] d);
        bus.mem_en[l]            = 1'b1;
        bus.mem_tag[l*AW +: AW]  = t;
        bus.mem_data[l*DW +: DW] = d;
    endtask

    task automatic readAllFive();
        for (int l = 0; l < NL; l++) begin
            setRs(l, 0, 5);
            setRs(l, 1, 5);
            setRd(l, 5);
        end
    endtask

    // Bundle X used by the stall test.
    task automatic bundleX();
        setRs(0, 0, 2);
        setRs(1, 1, 3);
        for (int l = 0; l < NL; l++) setRd(l, AW'(l + 1));
    endtask

    task automatic expectX(input string tag);
        expectOut({tag, "_v0"},  S_VAL,   0, 16'h0002);
        expectOut({tag, "_v3"},  S_VAL,   3, 16'h0007);
        expectOut({tag, "_rd"},  S_RDTAG, 0, VW'(rdX));
        expectOut({tag, "_cnd"}, S_CND,   0, 4'hF);
    endtask

    initial begin
        for (int i = 0; i < NL * 2; i++) allFive[i*AW +: AW] = 5'd5;
        rdX = {5'd4, 5'd3, 5'd2, 5'd1};
        clearInputs();

        // Power-on reset.
        rst_n = 1'b0;
        applyStimulus();
        applyStimulus();

        // Write R5, then reset for two cycles while reading R5 everywhere.
        applyStimulus(); rst_n = 1'b1; setWb(0, 5, 16'h1234);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(); rst_n = 1'b0; readAllFive();
            expectOut("rst_val", S_ALLVAL, 0, '0);
            expectOut("rst_tag", S_ALLTAG, 0, '0);
            expectOut("rst_rd",  S_RDTAG,  0, '0);
            expectOut("rst_cnd", S_CND,    0, '0);
`ifdef VLIW_ID_WR_CONFLICT_EN
            expectOut("rst_conf", S_CONF,  0, '0);
`endif
        end
        applyStimulus(); rst_n = 1'b1; readAllFive();
        expectOut("post_rst_r5", S_ALLVAL, 0, '0);
        expectOut("post_rst_tag", S_ALLTAG, 0, VW'(allFive));
        expectOut("post_rst_cnd", S_CND, 0, 4'hF);

        // Register file write then read on lane M.
        applyStimulus(); setWb(0, 1, 16'd5); setWb(1, 2, 16'd2);
        applyStimulus(); setRs(2, 0, 1); setRs(2, 1, 2);
        expectOut("rf_r1_laneM", S_VAL, 4, 16'd5);
        expectOut("rf_r2_laneM", S_VAL, 5, 16'd2);

        // Same-cycle write bypass.
        applyStimulus(); setWb(0, 3, 16'd7); setRs(0, 0, 3);
        expectOut("wb_bypass_r3", S_VAL, 0, 16'd7);

        // Forwarding priority ex > mem > rf.
        applyStimulus(); setWb(0, 1, 16'd9);
        applyStimulus(); setMem(0, 1, 16'd16); setEx(2, 1, 16'd5); setRs(0, 0, 1);
        expectOut("fwd_ex", S_VAL, 0, 16'd5);
        applyStimulus(); setMem(0, 1, 16'd16); setRs(0, 0, 1);
        expectOut("fwd_mem", S_VAL, 0, 16'd16);
        applyStimulus(); setRs(0, 0, 1);
        expectOut("fwd_rf", S_VAL, 0, 16'd9);

        // R0 never forwards and never gets written.
        applyStimulus(); setEx(0, 0, 16'h55); setMem(1, 0, 16'h44); setWb(0, 0, 16'h66);
        setRs(0, 0, 0); setRs(1, 1, 0);
        expectOut("r0_fwd_p0", S_VAL, 0, 16'd0);
        expectOut("r0_fwd_p3", S_VAL, 3, 16'd0);
        applyStimulus(); setRs(0, 0, 0);
        expectOut("r0_rf", S_VAL, 0, 16'd0);

        // ex beats same-cycle wb; wb lands in the RF.
        applyStimulus(); setEx(1, 1, 16'h11); setWb(0, 1, 16'h22); setRs(0, 0, 1);
        expectOut("ex_over_wb", S_VAL, 0, 16'h11);
        applyStimulus(); setRs(0, 1, 1);
        expectOut("wb_landed", S_VAL, 1, 16'h22);

        // Highest lane wins within each stage.
        applyStimulus(); setEx(0, 6, 16'd1); setEx(3, 6, 16'd2); setMem(2, 6, 16'd4); setRs(1, 0, 6);
        expectOut("ex_hi_lane", S_VAL, 2, 16'd2);
        applyStimulus(); setMem(0, 6, 16'd3); setMem(2, 6, 16'd4); setWb(3, 6, 16'd5); setRs(1, 0, 6);
        expectOut("mem_hi_lane", S_VAL, 2, 16'd4);
        applyStimulus(); setWb(0, 6, 16'd5); setWb(2, 6, 16'd6); setRs(1, 0, 6);
        expectOut("wb_hi_lane", S_VAL, 2, 16'd6);
        applyStimulus(); setRs(1, 0, 6);
        expectOut("rf_hi_lane", S_VAL, 2, 16'd6);

        // Predicate evaluation on lane 0; other lanes use cond=00.
        applyStimulus(); setEx(1, 30, 16'd0); setCond(0, 2'b01);
        expectOut("pred_eq0_p0", S_CND, 0, 4'hF);
        applyStimulus(); setEx(1, 30, 16'd0); setCond(0, 2'b10);
        expectOut("pred_ne0_p0", S_CND, 0, 4'hE);
        applyStimulus(); setEx(1, 30, 16'd0); setCond(0, 2'b11);
        expectOut("pred_never", S_CND, 0, 4'hE);
        applyStimulus(); setEx(1, 30, 16'd0); setCond(0, 2'b00);
        expectOut("pred_always", S_CND, 0, 4'hF);
        applyStimulus(); setEx(1, 30, 16'd3); setCond(0, 2'b10);
        expectOut("pred_ne0_p3", S_CND, 0, 4'hF);
        applyStimulus(); setEx(1, 30, 16'd3); setCond(0, 2'b01);
        expectOut("pred_eq0_p3", S_CND, 0, 4'hE);
        applyStimulus(); setWb(0, 30, 16'd9); setCond(0, 2'b01);
        expectOut("pred_wb_bypass", S_CND, 0, 4'hE);
        applyStimulus(); setCond(0, 2'b10);
        expectOut("pred_rf", S_CND, 0, 4'hF);
        applyStimulus(); setEx(1, 30, 16'd0); setCond(0, 2'b01);
        expectOut("pred_ex_over_rf", S_CND, 0, 4'hF);

        // Stall: load X, then present Y for three stalled cycles.
        applyStimulus(); bundleX();
        expectX("load_x");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(); bus.stall = 1'b1;
            setRs(0, 0, 1); setRs(1, 1, 1);
            for (int l = 0; l < NL; l++) begin
                setRd(l, 9);
                setCond(l, 2'b11);
            end
            if (k == 0) setWb(0, 2, 16'h0077);
            expectX("stall_hold");
        end
        applyStimulus(); bus.stall = 1'b1; bus.flush = 1'b1; bundleX();
        expectOut("flush_val", S_ALLVAL, 0, '0);
        expectOut("flush_tag", S_ALLTAG, 0, '0);
        expectOut("flush_rd",  S_RDTAG,  0, '0);
        expectOut("flush_cnd", S_CND,    0, '0);
        applyStimulus(); setRs(0, 0, 2);
        expectOut("write_in_stall", S_VAL, 0, 16'h0077);
`ifdef VLIW_ID_WR_CONFLICT_EN
        expectOut("conf_clear", S_CONF, 0, '0);
`endif

        // Two lanes write R4 in the same cycle; lane 3 wins.
        applyStimulus(); setWb(1, 4, 16'h00AA); setWb(3, 4, 16'h00BB);
`ifdef VLIW_ID_WR_CONFLICT_EN
        expectOut("conf_set", S_CONF, 0, 1);
`endif
        applyStimulus(); setRs(3, 0, 4);
        expectOut("conflict_r4", S_VAL, 6, 16'h00BB);
`ifdef VLIW_ID_WR_CONFLICT_EN
        expectOut("conf_sticky1", S_CONF, 0, 1);
`endif
        applyStimulus(); setRs(0, 0, 4);
        expectOut("conflict_r4_p0", S_VAL, 0, 16'h00BB);
`ifdef VLIW_ID_WR_CONFLICT_EN
        expectOut("conf_sticky2", S_CONF, 0, 1);
`endif

        // Reset during a stall still clears everything.
        applyStimulus(); rst_n = 1'b0; bus.stall = 1'b1; setRs(0, 0, 4);
        expectOut("rst_in_stall_val", S_ALLVAL, 0, '0);
        expectOut("rst_in_stall_cnd", S_CND, 0, '0);
`ifdef VLIW_ID_WR_CONFLICT_EN
        expectOut("conf_rst", S_CONF, 0, '0);
`endif
        applyStimulus(); rst_n = 1'b1; setRs(0, 0, 4);
        expectOut("rf_cleared_r4", S_VAL, 0, 16'd0);

        repeat (3) applyStimulus();
        if (expQ.size() != 0) begin
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
            failures += expQ.size();
            checks   += expQ.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
